div_sequencer: RTL

Operand-side sequencer and result formatter for the iterative fixed-point `divider`. It accepts an A_W-bit unsigned numerator and a B_W-bit unsigned denominator over a valid/ready handshake. It then forms the `{a, FRAC_W zeros}` dividend, drives the divider's `en` and waits for `divider_ok`. Finally it captures the quotient and presents a saturated OUT_W-bit result with status flags over a second valid/ready handshake.

---
 rtl/div_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: operand sequencer and result formatter for the iterative
// fixed-point divider. It takes an {a, b} pair in, runs one division and
// returns a saturated result with status flags.
module div_sequencer #(
   parameter int A_W     = 12,
   parameter int B_W     = 14,
   parameter int FRAC_W  = 14,
   parameter int OUT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [A_W-1:0]          in_a,
   input  logic [B_W-1:0]          in_b,
   output logic                    div_en,
   output logic [A_W+FRAC_W-1:0]   div_dividend,
   output logic [B_W-1:0]          div_divisor,
   input  logic [A_W+FRAC_W-1:0]   div_quotient,
   input  logic                    div_ok,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_q,
   output logic                    out_sat,
   output logic                    out_dz,
   output logic                    out_timeout,
   output logic                    busy
);

   localparam int M     = A_W + FRAC_W;
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [A_W-1:0]     a_reg;
   logic [B_W-1:0]     b_reg;
   logic [CNT_W-1:0]   cnt;
   logic               q_ovf;
   logic [OUT_W-1:0]   q_fmt;
   logic               accept;
   logic               b_zero;
   logic               timeout_hit;

   // Any set bit above the output field means the quotient does not fit.
   generate
      if (OUT_W < M) begin : g_ovf
         assign q_ovf = |div_quotient[M-1:OUT_W];
      end else begin : g_no_ovf
         assign q_ovf = 1'b0;
      end
   endgenerate

   assign q_fmt        = q_ovf ? {OUT_W{1'b1}} : div_quotient[OUT_W-1:0];
   assign accept       = in_valid && (state == S_IDLE);
   assign b_zero       = (in_b == '0);
   assign timeout_hit  = (cnt == CNT_W'(TIMEOUT - 1));
   assign div_dividend = {a_reg, {FRAC_W{1'b0}}};
   assign div_divisor  = b_reg;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state: div_ok wins over timeout when both land in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = b_zero ? S_DONE : S_WAIT;
         S_WAIT: if (div_ok || timeout_hit) state_nxt = S_DONE;
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake and divider-enable outputs decoded from state alone.
   always_comb begin
      in_ready  = (state == S_IDLE);
      div_en    = (state == S_WAIT);
      out_valid = (state == S_DONE);
      busy      = (state != S_IDLE);
   end

   // Operand latch, timeout counter and result/flag capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg       <= '0;
         b_reg       <= '0;
         cnt         <= '0;
         out_q       <= '0;
         out_sat     <= 1'b0;
         out_dz      <= 1'b0;
         out_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_reg <= in_a;
                  b_reg <= in_b;
                  cnt   <= '0;
                  // Divide by zero never reaches the divider.
                  if (b_zero) begin
                     out_q       <= {OUT_W{1'b1}};
                     out_sat     <= 1'b0;
                     out_dz      <= 1'b1;
                     out_timeout <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (div_ok) begin
                  out_q       <= q_fmt;
                  out_sat     <= q_ovf;
                  out_dz      <= 1'b0;
                  out_timeout <= 1'b0;
               end else if (timeout_hit) begin
                  out_q       <= '0;
                  out_sat     <= 1'b0;
                  out_dz      <= 1'b0;
                  out_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
